lms_readout_trainer: RTL

// Parametrised reservoir readout: holds N_NEURONS signed weights and computes y = sum(x_i*w_i)

---
 rtl/lms_readout_trainer_pkg.sv | 32 +++
 rtl/lms_readout_trainer_mac_sat.sv | 43 ++++
 rtl/lms_readout_trainer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lms_readout_trainer_pkg.sv
// lms_pkg: types and helpers shared by the LMS readout trainer.
//   state_t : controller states
//   clog2   : ceiling log2, used for accumulator and index widths
//   sat_s   : clamp a signed value into the range of a w-bit signed number
package lms_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC  = 3'd1,
    ERR  = 3'd2,
    UPD  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic longint sat_s(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lms_readout_trainer_mac_sat.sv
// lms_mac_sat: shared signed multiply / shift / saturating add.
//   op_a, op_b : signed multiplier operands
//   addend     : signed value added to the (optionally shifted) product
//   upd_mode   : 0 = accumulate (no shift, clamp to S_W bits)
//                1 = weight update (product >>> SHIFT, clamp to NARROW_W bits)
//   result     : clamped sum, sign-extended to S_W bits
//   sat        : clamping changed the sum
module lms_mac_sat
  import lms_pkg::*;
#(
  parameter int A_W      = 17,
  parameter int B_W      = 16,
  parameter int S_W      = 29,
  parameter int NARROW_W = 8,
  parameter int SHIFT    = 12
) (
  input  logic signed [A_W-1:0] op_a,
  input  logic signed [B_W-1:0] op_b,
  input  logic signed [S_W-1:0] addend,
  input  logic                  upd_mode,
  output logic signed [S_W-1:0] result,
  output logic                  sat
);

  localparam int P_W   = A_W + B_W;
  localparam int SUM_W = ((P_W > S_W) ? P_W : S_W) + 1;

  logic signed [P_W-1:0]   prod;
  logic signed [P_W-1:0]   prod_sh;
  logic signed [SUM_W-1:0] sum;
  longint                  lim;

  always_comb begin
    prod    = op_a * op_b;
    prod_sh = upd_mode ? (prod >>> SHIFT) : prod;
    sum     = {{(SUM_W-P_W){prod_sh[P_W-1]}}, prod_sh}
            + {{(SUM_W-S_W){addend[S_W-1]}}, addend};
    lim     = upd_mode ? sat_s(longint'(sum), NARROW_W) : sat_s(longint'(sum), S_W);
    result  = S_W'(lim);
    sat     = (lim != longint'(sum));
  end

endmodule

// File: rtl/lms_readout_trainer.sv
// lms_readout_trainer: reservoir readout y = sum(x_i*w_i) >>> W_FRAC computed serially on
// one shared multiplier, with an optional LMS weight step w_i += (e*x_i) >>> MU_SHIFT.
//   clk, rst_n       : clock, asynchronous active-low reset
//   training         : captured at accept; 1 = run the weight update for this sample
//   in_valid/in_ready: sample handshake (in_ready only in IDLE and not loading)
//   x_flat, y_target : neuron outputs and desired output
//   w_load, w_init_flat : load all weights (IDLE only)
//   out_valid        : one-cycle pulse, y_out/err_out/sat_flag valid, weights final
//   y_out, err_out   : saturated readout and y_target - y_out
//   sat_flag         : y or any weight saturated during this sample
//   w_flat           : current weights
//
// state | meaning
// IDLE  | waiting for a sample or a weight load
// ACC   | one MAC per cycle, index 0..N-1
// ERR   | scale/saturate y, form error
// UPD   | one weight update per cycle, index 0..N-1 (training only)
// DONE  | out_valid pulse
module lms_readout_trainer
  import lms_pkg::*;
#(
  parameter int N_NEURONS = 19,
  parameter int X_W       = 16,
  parameter int W_W       = 8,
  parameter int W_FRAC    = 6,
  parameter int MU_SHIFT  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     training,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_NEURONS*X_W-1:0] x_flat,
  input  logic [X_W-1:0]           y_target,
  input  logic                     w_load,
  input  logic [N_NEURONS*W_W-1:0] w_init_flat,
  output logic                     out_valid,
  output logic [X_W-1:0]           y_out,
  output logic [X_W:0]             err_out,
  output logic                     sat_flag,
  output logic [N_NEURONS*W_W-1:0] w_flat
);

  localparam int ACC_W = X_W + W_W + clog2(N_NEURONS);
  localparam int E_W   = X_W + 1;
  localparam int IDX_W = (clog2(N_NEURONS) > 0) ? clog2(N_NEURONS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);

  state_t state, state_nx;

  logic signed [X_W-1:0]   x_r [N_NEURONS];
  logic signed [W_W-1:0]   w_r [N_NEURONS];
  logic signed [X_W-1:0]   yt_r;
  logic                    train_r;
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        idx;
  logic signed [X_W-1:0]   y_r;
  logic signed [E_W-1:0]   e_r;
  logic                    sat_r;
  logic                    accept;

  logic signed [X_W-1:0]   x_cur;
  logic signed [W_W-1:0]   w_cur;
  logic signed [E_W-1:0]   mac_a;
  logic signed [X_W-1:0]   mac_b;
  logic signed [ACC_W-1:0] mac_add;
  logic signed [ACC_W-1:0] mac_res;
  logic                    mac_sat;
  logic                    upd_mode;

  logic signed [ACC_W-1:0] y_shift;
  longint                  y_lim;
  logic signed [X_W-1:0]   y_sat;
  logic                    y_sat_hit;
  logic signed [E_W-1:0]   e_next;

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        // a pending load takes priority; the sample is taken the cycle after
        in_ready = !w_load;
        if (in_valid && !w_load) state_nx = ACC;
      end
      ACC:     if (idx == IDX_LAST) state_nx = ERR;
      ERR:     state_nx = train_r ? UPD : DONE;
      UPD:     if (idx == IDX_LAST) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Operand mux for the shared MAC
  assign x_cur    = x_r[idx];
  assign w_cur    = w_r[idx];
  assign upd_mode = (state == UPD);

  always_comb begin
    mac_a   = {x_cur[X_W-1], x_cur};
    mac_b   = {{(X_W-W_W){w_cur[W_W-1]}}, w_cur};
    mac_add = acc;
    if (upd_mode) begin
      mac_a   = e_r;
      mac_b   = x_cur;
      mac_add = {{(ACC_W-W_W){w_cur[W_W-1]}}, w_cur};
    end
  end

  lms_mac_sat #(
    .A_W      (E_W),
    .B_W      (X_W),
    .S_W      (ACC_W),
    .NARROW_W (W_W),
    .SHIFT    (MU_SHIFT)
  ) u_mac (
    .op_a     (mac_a),
    .op_b     (mac_b),
    .addend   (mac_add),
    .upd_mode (upd_mode),
    .result   (mac_res),
    .sat      (mac_sat)
  );

  // Readout scaling and error
  always_comb begin
    y_shift   = acc >>> W_FRAC;
    y_lim     = sat_s(longint'(y_shift), X_W);
    y_sat     = X_W'(y_lim);
    y_sat_hit = (y_lim != longint'(y_shift));
    e_next    = {yt_r[X_W-1], yt_r} - {y_sat[X_W-1], y_sat};
  end

  // Datapath and weight register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        w_r[i] <= '0;
        x_r[i] <= '0;
      end
      yt_r    <= '0;
      train_r <= 1'b0;
      acc     <= '0;
      idx     <= '0;
      y_r     <= '0;
      e_r     <= '0;
      sat_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (w_load) begin
            for (int i = 0; i < N_NEURONS; i++) w_r[i] <= w_init_flat[i*W_W +: W_W];
          end else if (accept) begin
            for (int i = 0; i < N_NEURONS; i++) x_r[i] <= x_flat[i*X_W +: X_W];
            yt_r    <= y_target;
            train_r <= training;
            acc     <= '0;
            sat_r   <= 1'b0;
          end
        end
        ACC: begin
          acc <= mac_res;
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        ERR: begin
          y_r   <= y_sat;
          e_r   <= e_next;
          sat_r <= y_sat_hit;
        end
        UPD: begin
          w_r[idx] <= mac_res[W_W-1:0];
          sat_r    <= sat_r | mac_sat;
          idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_wflat
    assign w_flat[g*W_W +: W_W] = w_r[g];
  end

  assign y_out    = y_r;
  assign err_out  = e_r;
  assign sat_flag = out_valid & sat_r;

endmodule
